// File: rtl/regfile_param.sv
// Parametrised register file: two write ports (port 1 wins), combinational
// read ports with optional write bypass, and a per-register busy scoreboard.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en0,
  input  logic [ADDR_W-1:0]          wr_addr0,
  input  logic [DATA_W-1:0]          wr_data0,
  input  logic                       wr_en1,
  input  logic [ADDR_W-1:0]          wr_addr1,
  input  logic [DATA_W-1:0]          wr_data1,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] w_regs [NREG];
  logic [NREG-1:0]   w_busy;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
    if (ZERO_REG != 0 && g == 0) begin : g_zero
      assign w_regs[g] = '0;
      assign w_busy[g] = 1'b0;
    end else begin : g_store
      logic [DATA_W-1:0] r_q;
      logic              r_b;
      logic              w_hit0;
      logic              w_hit1;

      assign w_hit0 = wr_en0 && (wr_addr0 == IDX);
      assign w_hit1 = wr_en1 && (wr_addr1 == IDX);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
          r_b <= 1'b0;
        end else begin
          if (w_hit1)      r_q <= wr_data1;
          else if (w_hit0) r_q <= wr_data0;
          // a newly issued producer outranks a completing write
          if (busy_set && (busy_addr == IDX)) r_b <= 1'b1;
          else if (w_hit0 || w_hit1)          r_b <= 1'b0;
        end
      end

      assign w_regs[g] = r_q;
      assign w_busy[g] = r_b;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = w_regs[w_addr];
      w_bsy  = w_busy[w_addr];
      if (ZERO_REG != 0 && w_addr == '0) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end else if (BYPASS != 0 && wr_en1 && wr_addr1 == w_addr) begin
        w_data = wr_data1;
        w_bsy  = 1'b0;
      end else if (BYPASS != 0 && wr_en0 && wr_addr0 == w_addr) begin
        w_data = wr_data0;
        w_bsy  = 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = w_data;
    assign rd_busy[p]                  = w_bsy;
  end

  assign busy_vec = w_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench: default instance (a), no-bypass/no-zero-reg instance (b)
// sharing stimulus, and a 32-bit / 32-register / 3-port instance (c).
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic        wr_en0, wr_en1, busy_set;
  logic [3:0]  wr_addr0, wr_addr1, busy_addr;
  logic [15:0] wr_data0, wr_data1;
  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [15:0] busy_vec_a, busy_vec_b;

  logic [14:0] rd_addr_c;
  logic        wr_en0_c, wr_en1_c, busy_set_c;
  logic [4:0]  wr_addr0_c, wr_addr1_c, busy_addr_c;
  logic [31:0] wr_data0_c, wr_data1_c;
  logic [95:0] rd_data_c;
  logic [2:0]  rd_busy_c;
  logic [31:0] busy_vec_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_param dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(busy_vec_a)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(busy_vec_b)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) dut_c (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wr_en0(wr_en0_c), .wr_addr0(wr_addr0_c), .wr_data0(wr_data0_c),
    .wr_en1(wr_en1_c), .wr_addr1(wr_addr1_c), .wr_data1(wr_data1_c),
    .busy_set(busy_set_c), .busy_addr(busy_addr_c), .busy_vec(busy_vec_c)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en0 = 1'b0; wr_en1 = 1'b0; busy_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    busy_set = 1'b0; busy_addr = '0;
    rd_addr_c = '0;
    wr_en0_c = 1'b0; wr_addr0_c = '0; wr_data0_c = '0;
    wr_en1_c = 1'b0; wr_addr1_c = '0; wr_data1_c = '0;
    busy_set_c = 1'b0; busy_addr_c = '0;

    #2;
    check("reset_data_a", rd_data_a, 32'h0);
    check("reset_busy_a", busy_vec_a, 16'h0);
    check("reset_busy_c", busy_vec_c, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // write FACE to r10; bypass visible only on a
    rd_addr = {4'd0, 4'd10};
    wr_en0 = 1'b1; wr_addr0 = 4'd10; wr_data0 = 16'hFACE;
    busy_set = 1'b1; busy_addr = 4'd7;
    #1;
    check("wr_bypass_a", rd_data_a[15:0], 16'hFACE);
    check("wr_nobypass_b", rd_data_b[15:0], 16'h0000);
    tick();
    idle();
    #1;
    check("wr_stored_a", rd_data_a[15:0], 16'hFACE);
    check("wr_stored_b", rd_data_b[15:0], 16'hFACE);
    check("busy7_a", busy_vec_a, 16'h0080);

    // asynchronous reset between edges
    rst = 1'b1;
    #1;
    check("async_rst_data_a", rd_data_a[15:0], 16'h0000);
    check("async_rst_data_b", rd_data_b[15:0], 16'h0000);
    check("async_rst_busy_a", busy_vec_a, 16'h0000);
    rst = 1'b0;
    tick();

    wr_en0 = 1'b1; wr_addr0 = 4'd10; wr_data0 = 16'hFACE;
    tick();
    idle();

    // bypass of a new write over existing FACE
    wr_en0 = 1'b1; wr_addr0 = 4'd10; wr_data0 = 16'h1111;
    #1;
    check("bypass_same_a", rd_data_a[15:0], 16'h1111);
    check("bypass_old_b", rd_data_b[15:0], 16'hFACE);
    tick();
    check("bypass_after_a", rd_data_a[15:0], 16'h1111);
    idle();
    #1;
    check("bypass_after_b", rd_data_b[15:0], 16'h1111);

    // dual-write collision on r5, read on port 1
    rd_addr = {4'd5, 4'd10};
    wr_en0 = 1'b1; wr_addr0 = 4'd5; wr_data0 = 16'h2222;
    wr_en1 = 1'b1; wr_addr1 = 4'd5; wr_data1 = 16'h3333;
    #1;
    check("collide_bypass_a", rd_data_a[31:16], 16'h3333);
    check("collide_old_b", rd_data_b[31:16], 16'h0000);
    tick();
    idle();
    #1;
    check("collide_a", rd_data_a, {16'h3333, 16'h1111});
    check("collide_b", rd_data_b[31:16], 16'h3333);

    // zero register: write and busy_set to r0
    rd_addr = {4'd5, 4'd0};
    wr_en0 = 1'b1; wr_addr0 = 4'd0; wr_data0 = 16'h2222;
    busy_set = 1'b1; busy_addr = 4'd0;
    #1;
    check("zero_same_a", rd_data_a[15:0], 16'h0000);
    check("zero_busy_same_a", rd_busy_a[0], 1'b0);
    tick();
    idle();
    #1;
    check("zero_after_a", rd_data_a[15:0], 16'h0000);
    check("zero_rdbusy_a", rd_busy_a[0], 1'b0);
    check("zero_vec_a", busy_vec_a[0], 1'b0);
    check("nozero_b", rd_data_b[15:0], 16'h2222);
    check("nozero_busy_b", rd_busy_b[0], 1'b1);

    // scoreboard on r3, read on port 1
    rd_addr = {4'd3, 4'd3};
    busy_set = 1'b1; busy_addr = 4'd3;
    #1;
    check("busy_not_yet_a", rd_busy_a, 2'b00);
    tick();
    idle();
    #1;
    check("busy_set_vec_a", busy_vec_a, 16'h0008);
    check("busy_set_rd_a", rd_busy_a, 2'b11);

    wr_en1 = 1'b1; wr_addr1 = 4'd3; wr_data1 = 16'h0033;
    #1;
    check("busy_wr_bypass_a", rd_busy_a, 2'b00);
    check("busy_wr_data_a", rd_data_a, {16'h0033, 16'h0033});
    check("busy_wr_old_b", rd_busy_b, 2'b11);
    tick();
    idle();
    #1;
    check("busy_clr_vec_a", busy_vec_a, 16'h0000);
    check("busy_clr_vec_b", busy_vec_b, 16'h0001);

    busy_set = 1'b1; busy_addr = 4'd3;
    wr_en0 = 1'b1; wr_addr0 = 4'd3; wr_data0 = 16'h4444;
    tick();
    idle();
    #1;
    check("set_wins_vec_a", busy_vec_a, 16'h0008);
    check("set_wins_vec_b", busy_vec_b, 16'h0009);
    check("set_wins_data_a", rd_data_a, {16'h4444, 16'h4444});
    check("set_wins_rd_a", rd_busy_a, 2'b11);

    // wide instance: fill r1..r31, then read three ports at once
    for (int i = 1; i < 32; i++) begin
      wr_en0_c = 1'b1; wr_addr0_c = 5'(i); wr_data0_c = 32'hA5A50000 + 32'(i);
      tick();
    end
    wr_en0_c = 1'b0;
    rd_addr_c = {5'd3, 5'd2, 5'd1};
    #1;
    check("c_read_1_2_3", rd_data_c, {32'hA5A50003, 32'hA5A50002, 32'hA5A50001});
    rd_addr_c = {5'd9, 5'd17, 5'd31};
    #1;
    check("c_read_31_17_9", rd_data_c, {32'hA5A50009, 32'hA5A50011, 32'hA5A5001F});
    rd_addr_c = {5'd0, 5'd10, 5'd10};
    #1;
    check("c_read_10_10_0", rd_data_c, {32'h00000000, 32'hA5A5000A, 32'hA5A5000A});
    check("c_busy_idle", busy_vec_c, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file: the next generation of the 16×16 CPU register file. It is generalised in data width, register count and read-port count, and adds two write ports, same-cycle write-to-read bypass, and a per-register busy scoreboard for the pipeline's hazard logic. It sits between decode (read/issue) and writeback (write), and replaces the fixed-size register file one-for-one when the parameters are left at their defaults.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width; NREG = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never goes busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read address; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational; port p uses [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard busy bit of the addressed register, combinational
- wr_en0  in  1  write port 0 enable
- wr_addr0  in  ADDR_W  write port 0 index
- wr_data0  in  DATA_W  write port 0 data
- wr_en1  in  1  write port 1 enable (higher priority)
- wr_addr1  in  ADDR_W  write port 1 index
- wr_data1  in  DATA_W  write port 1 data
- busy_set  in  1  mark register busy_addr as having a pending producer
- busy_addr  in  ADDR_W  register to mark busy
- busy_vec  out  NREG  all busy bits, registered

## Operation
- Storage: NREG × DATA_W flops plus NREG busy flops. With ZERO_REG=1, register 0 has no storage.
- Write: on a clock edge, reg[wr_addrN] <= wr_dataN when wr_enN is set. If both ports target the same address, port 1's data is stored and port 0's is dropped.
- Busy update per register r on a clock edge, in priority order:
  - busy_set with busy_addr==r → busy[r]=1. Set wins over a clear: a new producer was issued.
  - otherwise, any enabled write to r → busy[r]=0.
  - otherwise busy[r] holds.
- Read, port p, combinational:
  - if ZERO_REG and rd_addr==0 → data 0, busy 0.
  - else if BYPASS, wr_en1 and wr_addr1==rd_addr → wr_data1, busy 0.
  - else if BYPASS, wr_en0 and wr_addr0==rd_addr → wr_data0, busy 0.
  - else → reg[rd_addr] and busy[rd_addr].
- A busy_set arriving in the same cycle does not affect this cycle's rd_busy; it is visible next cycle.
- With BYPASS=0, a read of a register being written returns the old value and the old busy bit.
- Read ports are fully independent. Any number of ports may address the same register.
- Writes and busy_set targeting register 0 are ignored when ZERO_REG=1.
- Width rules: no arithmetic is performed. All addresses are in range by construction, since NREG = 2**ADDR_W.

## Timing
- Reset: asserting rst immediately, without waiting for a clock, clears every register to 0 and every busy bit to 0. During and after reset: rd_data reads all zeros (absent bypass hits), rd_busy=0, busy_vec=0.
- rst dominates: writes and busy_set in any cycle where rst is high are lost.
- Deassertion is sampled synchronously by the surrounding design. The first write may occur on the first edge with rst low.
- Write latency: 1 edge to storage, 0 cycles to readers when BYPASS=1, 1 cycle when BYPASS=0.
- busy_set latency: 1 edge to busy_vec and rd_busy.
- Write-clears-busy latency: 1 edge to busy_vec. rd_busy reads 0 in the write cycle itself when BYPASS=1.
- Read ports have no internal state; their outputs settle combinationally from rd_addr, storage and the write ports.

## Test plan
- Reset mid-operation: write 0xFACE to r10, then pulse rst between clock edges → rd_data for r10 reads 0x0000 before the next edge, and busy_vec=0.
- Bypass: BYPASS=1, wr_en0=1, wr_addr0=0xA, wr_data0=0x1111, rd_addr port 0 = 0xA → rd_data=0x1111 in the same cycle, and 0x1111 still after the edge. With BYPASS=0, the same stimulus reads the old value 0xFACE until the edge.
- Dual-write collision: both ports write r5 in one cycle, port 0 with 0x2222 and port 1 with 0x3333 → r5 reads 0x3333 next cycle. The same-cycle bypass also returns 0x3333.
- Zero register: ZERO_REG=1, write 0x2222 to r0 and busy_set r0 → r0 reads 0x0000, rd_busy=0, busy_vec[0]=0. With ZERO_REG=0 the same stimulus → r0 reads 0x2222.
- Scoreboard:
  - busy_set r3 → busy_vec[3]=1 the next cycle.
  - a write to r3 → busy_vec[3]=0 the following cycle.
  - busy_set r3 together with a write to r3 in one cycle → busy_vec[3]=1 and data updated.
- Parametrisation: DATA_W=32, ADDR_W=5, NUM_RD=3. Write distinct values 0xA5A50000+i to all 31 non-zero registers, then read them on 3 ports with different addresses → every port returns the correct value and no two ports interfere.
